// File: rtl/byte_unstriping.sv
// Four-lane group to byte-stream unstriper with a 2-entry group buffer
// and a PCIe-style STP/SDP..END/EDB framing checker.
module byte_unstriping #(
  parameter int LANES = 4,
  parameter int BITS  = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] LANE0,
  input  logic [BITS-1:0] LANE1,
  input  logic [BITS-1:0] LANE2,
  input  logic [BITS-1:0] LANE3,
  input  logic            DK_0,
  input  logic            DK_1,
  input  logic            DK_2,
  input  logic            DK_3,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [BITS-1:0] D,
  output logic            DK,
  output logic            D_VALID,
  output logic [1:0]      FRAME,
  output logic            ERR
);

  localparam int unsigned GW = LANES * BITS;

  localparam logic [BITS-1:0] K_STP = BITS'(8'hFB);
  localparam logic [BITS-1:0] K_SDP = BITS'(8'h5C);
  localparam logic [BITS-1:0] K_END = BITS'(8'hFD);
  localparam logic [BITS-1:0] K_EDB = BITS'(8'hFE);
  localparam logic [BITS-1:0] K_COM = BITS'(8'hBC);
  localparam logic [BITS-1:0] K_SKP = BITS'(8'h1C);
  localparam logic [BITS-1:0] K_IDL = BITS'(8'h7C);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_DLLP = 2'd2
  } frame_t;

  logic [GW-1:0]    r_buf_d [2];
  logic [LANES-1:0] r_buf_k [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [1:0]       r_idx;
  frame_t           r_state;
  logic [BITS-1:0]  r_d;
  logic             r_dk;
  logic             r_dvalid;
  logic             r_err;

  logic [GW-1:0]    w_in_d;
  logic [LANES-1:0] w_in_k;
  logic [GW-1:0]    w_head_d;
  logic [LANES-1:0] w_head_k;
  logic [BITS-1:0]  w_cur_b;
  logic             w_cur_k;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_err;
  frame_t           w_next;

  assign w_in_d   = {LANE3, LANE2, LANE1, LANE0};
  assign w_in_k   = {DK_3, DK_2, DK_1, DK_0};
  assign IN_READY = (r_count < 2'd2) && !RESET;
  assign w_push   = IN_VALID && IN_READY;
  assign w_pop    = (r_count != 2'd0) && (r_idx == 2'd3);
  assign w_head_d = r_buf_d[r_rd_ptr];
  assign w_head_k = r_buf_k[r_rd_ptr];
  assign w_cur_b  = w_head_d[BITS*int'(r_idx) +: BITS];
  assign w_cur_k  = w_head_k[r_idx];

  assign D       = r_d;
  assign DK      = r_dk;
  assign D_VALID = r_dvalid;
  assign FRAME   = r_state;
  assign ERR     = r_err;

  // Group storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_buf_d[r_wr_ptr] <= w_in_d;
      r_buf_k[r_wr_ptr] <= w_in_k;
    end
  end

  // Framing decode for the slot currently selected by idx.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_drop = w_cur_k && ((w_cur_b == K_SKP) || (w_cur_b == K_IDL));
    if (!w_cur_k) begin
      if (r_state == ST_IDLE) w_err = 1'b1;
    end else begin
      case (w_cur_b)
        K_STP: begin
          w_err  = (r_state != ST_IDLE);
          w_next = ST_TLP;
        end
        K_SDP: begin
          w_err  = (r_state != ST_IDLE);
          w_next = ST_DLLP;
        end
        K_END: begin
          w_err  = (r_state == ST_IDLE);
          w_next = ST_IDLE;
        end
        K_EDB: begin
          w_err  = (r_state != ST_TLP);
          w_next = ST_IDLE;
        end
        K_COM, K_SKP, K_IDL: ;
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_idx    <= 2'd0;
      r_state  <= ST_IDLE;
      r_d      <= '0;
      r_dk     <= 1'b0;
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (r_count != 2'd0) begin
        r_idx    <= r_idx + 2'd1;
        r_d      <= w_cur_b;
        r_dk     <= w_cur_k;
        r_dvalid <= !w_drop;
        r_err    <= w_err && !w_drop;
        if (!w_drop) r_state <= w_next;
      end else begin
        r_idx    <= 2'd0;
        r_dvalid <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Downstream companion to the byte striper. It accepts one 4-lane group per handshake: a data byte plus a K-flag on each lane. It re-serialises the group into a single byte stream (lane 0 first) at one byte per CLK. A two-entry group buffer decouples arrival from drain. A framing checker tracks STP/SDP…END/EDB packet boundaries, drops SKP/IDL fillers, and flags framing violations.

## Interface
- LANES, 4, number of lanes; the block is defined for 4 only.
- BITS, 8, byte width.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- LANE0..LANE3  in  BITS each  lane bytes; LANE0 is the earliest byte of the group.
- DK_0..DK_3  in  1 each  1 means the matching lane byte is a K-symbol.
- IN_VALID  in  1  lane inputs carry a group this cycle.
- IN_READY  out  1  buffer can accept a group.
- D  out  BITS  serialised byte.
- DK  out  1  K-flag of D.
- D_VALID  out  1  D/DK carry a delivered byte.
- FRAME  out  2  framing state after the byte on D: 0 IDLE, 1 TLP, 2 DLLP.
- ERR  out  1  one-cycle framing-violation pulse.

## Operation
- K-codes: STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C.
- Accept: a group (4×(BITS+1) bits) is written to the buffer on an edge where IN_VALID && IN_READY. IN_VALID with IN_READY=0 is ignored, with no side effects.
- Buffer: 2-entry FIFO with count 0..2.
  - IN_READY = (count<2) && !RESET. It is combinational from count only, with no pass-through on pop.
  - A simultaneous push and pop is legal, and count is unchanged.
- Serialiser: a 2-bit slot index idx walks 0,1,2,3 over the head group while count>0.
  - Each cycle it registers lane[idx] and DK_idx onto D/DK.
  - At idx=3 the head is popped and idx wraps to 0.
  - With count=0, idx holds at 0 and D_VALID=0.
- Filler drop: a slot byte with DK=1 and code SKP or IDL still consumes its slot. D_VALID=0 for it, D/DK still show the byte, and FRAME is unchanged.
- Framing FSM, evaluated per non-dropped slot:
  - IDLE
    - K STP → TLP.
    - K SDP → DLLP.
    - K END/EDB → ERR, stay IDLE.
    - Data byte (DK=0) → ERR, stay IDLE.
  - TLP
    - Data → stay.
    - K END or EDB → IDLE.
    - K STP/SDP → ERR, then enter TLP/DLLP per the code (restart).
  - DLLP
    - Data → stay.
    - K END → IDLE.
    - K EDB → ERR, IDLE.
    - K STP/SDP → ERR, restart.
  - In any state, K COM is delivered (D_VALID=1) with no state change.
  - In any state, a K code outside the table gives ERR with no state change.
  - Every non-dropped slot is delivered with D_VALID=1, including erroneous ones.
- Reset (asynchronous, any time, including mid-group):
  - The FIFO is flushed, count=0, idx=0, FSM=IDLE.
  - D=0, DK=0, D_VALID=0, FRAME=0, ERR=0, IN_READY=0.
  - A partially serialised group is discarded.

## Timing
- Latency: a group accepted at edge k with an empty buffer puts LANE0 on D after edge k+1. LANE1, LANE2 and LANE3 follow after edges k+2, k+3 and k+4.
- ERR and FRAME are registered together with D; they describe the byte currently on D.
- Sustained throughput is 1 group per 4 CLK. IN_VALID every 4th cycle never stalls.
- Back-to-back groups on consecutive cycles are both accepted, after which count=2 and IN_READY=0.
  - IN_READY returns to 1 on the edge that pops the first group.
  - That pop happens 4 cycles after serialisation of the first group started.
- Between groups there is no bubble: the LANE3 slot of group n is followed directly by the LANE0 slot of group n+1.
- On the first CLK edge after RESET falls, IN_READY=1 and D_VALID=0.

## Test plan
- Reset mid-serialisation:
  - Stimulus: RESET asserted while idx=2.
  - Required: D_VALID, ERR, FRAME and IN_READY go to 0 immediately, without waiting for an edge.
  - Required after release: the next accepted group starts at LANE0, and no stale bytes appear.
- TLP:
  - Stimulus: group {FB,33,FF,FD}, DK {1,0,0,1}, accepted at edge k.
  - Required: D = FB, 33, FF, FD after edges k+1..k+4, each with D_VALID=1.
  - Required: FRAME = 1, 1, 1, 0 and ERR stays 0.
- DLLP then nullified-TLP error:
  - Stimulus: {5C,55,41,FD}, DK {1,0,0,1}, then {5C,55,41,FE}, DK {1,0,0,1}.
  - Required: the first group gives no ERR.
  - Required: in the second group, ERR pulses only in the FE slot and FRAME is 0 afterwards.
- Fillers:
  - Stimulus: {1C,FB,7C,FD}, DK all 1.
  - Required: D_VALID = 0, 1, 0, 1 and ERR=0.
  - Required: FRAME goes 0→1 at FB and back to 0 at FD.
- Backpressure:
  - Stimulus: IN_VALID held high for 3 consecutive cycles on an empty block.
  - Required: the first 2 groups are accepted and IN_READY=0 on the third cycle, so the third group is not accepted.
  - Required: output is 8 contiguous valid slots with no duplication.
- Framing errors:
  - Stimulus: data byte 12 (DK=0) in IDLE → ERR=1, FRAME=0.
  - Stimulus: STP followed by STP → ERR on the second STP, FRAME stays 1.
  - Stimulus: unknown K code AA → ERR with FRAME unchanged.
